// File: rtl/mem_arbiter_pkg.sv
// mem_arb_types: shared types for the memory-port arbiter.
//
// Contents:
//   arb_state_t  - arbiter FSM states (IDLE, SERVE_I, SERVE_D, DONE)
//   requester_t  - identity of a port owner, used for round-robin history
//   mem_op_t     - operation recorded at grant time and replayed on the pmem port
//   Grant*       - encodings of the 2-bit grant output
package mem_arb_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } requester_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

  localparam logic [1:0] GrantNone = 2'b00;
  localparam logic [1:0] GrantI    = 2'b01;
  localparam logic [1:0] GrantD    = 2'b10;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-sized physical-memory port between the I-cache
// fill path and the D-cache fill/write-back path.
//
// One transaction is in flight at a time. A grant captures the winner's address
// (and write data for a D write-back) into local registers, so the pmem side never
// follows requester inputs after the grant. Ties are broken round-robin against the
// last owner; after reset the I-cache counts as last owner, so the D-cache wins the
// first tie. Every transaction ends with a single dead cycle (DONE) in which all
// requests are ignored, so a request still held in the cycle after its resp is not
// granted a second time.
//
// Ports:
//   clk, rst                 - clock (rising edge), asynchronous active-high reset
//   icache_read/_address     - I-cache fill request (level) and line address
//   icache_rdata/_resp       - fill data and one-cycle completion pulse
//   dcache_read/_write       - D-cache fill / write-back requests (level)
//   dcache_address/_wdata    - D-cache line address and write-back data
//   dcache_rdata/_resp       - fill data and one-cycle completion pulse
//   pmem_read/_write         - memory strobes, held until pmem_resp
//   pmem_address/_wdata      - registered transaction address and write data
//   pmem_rdata/_resp         - memory read data and completion pulse
//   grant                    - current owner: 00 none, 01 I-cache, 10 D-cache
module mem_arbiter
  import mem_arb_types::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  icache_read,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,

  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,

  output logic [1:0]            grant
);

  arb_state_t            state_q;
  requester_t            last_grant_q;
  mem_op_t               op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;

  logic i_pending;
  logic d_pending;
  logic pick_d;
  logic serving;

  // D wins when it is the only requester, or on a tie when I owned the port last.
  always_comb begin
    i_pending = icache_read;
    d_pending = dcache_read | dcache_write;
    pick_d    = d_pending & (~i_pending | (last_grant_q == ICACHE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ICACHE;
      op_q         <= OP_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_d) begin
            state_q      <= SERVE_D;
            last_grant_q <= DCACHE;
            addr_q       <= dcache_address;
            // A write-back outranks a fill if both are (illegally) raised together.
            if (dcache_write) begin
              op_q    <= OP_WRITE;
              wdata_q <= dcache_wdata;
            end else begin
              op_q    <= OP_READ;
            end
          end else if (i_pending) begin
            state_q      <= SERVE_I;
            last_grant_q <= ICACHE;
            addr_q       <= icache_address;
            op_q         <= OP_READ;
          end
        end
        // The transaction completes even if the requester dropped its level early.
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Strobes, address and data all derive from registers only.
  always_comb begin
    serving      = (state_q == SERVE_I) || (state_q == SERVE_D);
    pmem_read    = serving && (op_q == OP_READ);
    pmem_write   = serving && (op_q == OP_WRITE);
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
  end

  always_comb begin
    unique case (state_q)
      SERVE_I: grant = GrantI;
      SERVE_D: grant = GrantD;
      default: grant = GrantNone;
    endcase
  end

  // Completion is forwarded in the same cycle as pmem_resp; read data is not gated.
  always_comb begin
    icache_resp  = (state_q == SERVE_I) && pmem_resp;
    dcache_resp  = (state_q == SERVE_D) && pmem_resp;
    icache_rdata = pmem_rdata;
    dcache_rdata = pmem_rdata;
  end

`ifndef SYNTHESIS
  // Fill and write-back from the D-cache must never be requested together.
  a_dcache_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(dcache_read && dcache_write));

  // Memory must only complete while a transaction is outstanding.
  a_pmem_resp_in_serve: assert property (@(posedge clk) disable iff (rst)
    !(pmem_resp && !serving));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          icache_read = 1'b0;
  logic [AW-1:0] icache_address = '0;
  logic [LW-1:0] icache_rdata;
  logic          icache_resp;
  logic          dcache_read = 1'b0;
  logic          dcache_write = 1'b0;
  logic [AW-1:0] dcache_address = '0;
  logic [LW-1:0] dcache_wdata = '0;
  logic [LW-1:0] dcache_rdata;
  logic          dcache_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic [1:0]    grant;

  mem_arbiter #(
    .ADDR_WIDTH(AW),
    .LINE_WIDTH(LW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .icache_read   (icache_read),
    .icache_address(icache_address),
    .icache_rdata  (icache_rdata),
    .icache_resp   (icache_resp),
    .dcache_read   (dcache_read),
    .dcache_write  (dcache_write),
    .dcache_address(dcache_address),
    .dcache_wdata  (dcache_wdata),
    .dcache_rdata  (dcache_rdata),
    .dcache_resp   (dcache_resp),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp),
    .grant         (grant)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Line memory shared by the responder and the reference model.
  logic [LW-1:0] mem_model [logic [AW-1:0]];
  int            mem_lat = 0;  // -1 selects a random latency per transaction

  // Completion bookkeeping observed on the cache side.
  bit i_done = 1'b0;
  bit d_done = 1'b0;
  int n_i_resp = 0;
  int n_d_resp = 0;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] mem_get(input logic [AW-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {8{a ^ 32'h5EED_0000}};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return AW'($urandom_range(0, 15)) << 5;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_any_resp(input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound && !ok; c++) begin
      @(negedge clk);
      if (icache_resp || dcache_resp) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    icache_read  = 1'b0;
    dcache_read  = 1'b0;
    dcache_write = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Memory: answers each strobe after mem_lat cycles (0 = same cycle as the strobe).
  initial begin : responder
    int cnt;
    cnt = -1;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      step();
      pmem_resp  = 1'b0;
      pmem_rdata = rand_line();
      if (rst) begin
        cnt = -1;
      end else begin
        if (cnt < 0 && (pmem_read || pmem_write))
          cnt = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        if (cnt == 0) begin
          pmem_resp = 1'b1;
          if (pmem_read) pmem_rdata = mem_get(pmem_address);
          cnt = -1;
        end else if (cnt > 0) begin
          cnt--;
        end
      end
    end
  end

  // Reference model: one owner at a time, round-robin on ties (I counts as last owner
  // after reset), grant decided from requests in a free cycle, pmem served from the
  // captured request, and one idle cycle after every completion.
  initial begin : monitor
    int            m_owner;   // 0 free, 1 I-cache, 2 D-cache
    int            m_last;
    bit            m_cool;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    m_owner = 0; m_last = 1; m_cool = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_owner = 0; m_last = 1; m_cool = 1'b0;
      end else begin
        if (icache_resp) begin n_i_resp++; i_done = 1'b1; end
        if (dcache_resp) begin n_d_resp++; d_done = 1'b1; end
        if (m_cool) begin
          check("mon_cool_grant", LW'(grant), '0);
          check("mon_cool_strobe", LW'({pmem_read, pmem_write}), '0);
          check("mon_cool_resp", LW'({icache_resp, dcache_resp}), '0);
          m_cool = 1'b0;
        end else if (m_owner == 0) begin
          check("mon_free_grant", LW'(grant), '0);
          check("mon_free_strobe", LW'({pmem_read, pmem_write}), '0);
          check("mon_free_resp", LW'({icache_resp, dcache_resp}), '0);
          if ((dcache_read || dcache_write) && (!icache_read || m_last == 1)) begin
            m_owner = 2; m_last = 2;
            m_addr = dcache_address; m_wr = dcache_write; m_wdata = dcache_wdata;
          end else if (icache_read) begin
            m_owner = 1; m_last = 1;
            m_addr = icache_address; m_wr = 1'b0;
          end
        end else begin
          check("mon_grant", LW'(grant), LW'(m_owner));
          check("mon_strobe", LW'({pmem_read, pmem_write}), m_wr ? LW'(1) : LW'(2));
          check("mon_addr", LW'(pmem_address), LW'(m_addr));
          if (m_wr) check("mon_wdata", pmem_wdata, m_wdata);
          if (pmem_resp) begin
            check("mon_resp", LW'({icache_resp, dcache_resp}), (m_owner == 1) ? LW'(2) : LW'(1));
            if (!m_wr) check("mon_rdata", (m_owner == 1) ? icache_rdata : dcache_rdata,
                             mem_get(m_addr));
            else mem_model[m_addr] = m_wdata;
            m_owner = 0;
            m_cool  = 1'b1;
          end else begin
            check("mon_resp_idle", LW'({icache_resp, dcache_resp}), '0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    int n_i_issued;
    int n_d_issued;
    logic [LW-1:0] a5_line;
    logic [LW-1:0] wb_line;
    a5_line = {32{8'hA5}};
    wb_line = {8{32'h1234_5678}};
    mem_model[32'h40] = a5_line;

    // Reset values, while rst is held and just after release.
    step();
    check("rst_grant", LW'(grant), '0);
    check("rst_strobes", LW'({pmem_read, pmem_write}), '0);
    check("rst_resps", LW'({icache_resp, dcache_resp}), '0);
    check("rst_addr", LW'(pmem_address), '0);
    check("rst_wdata", pmem_wdata, '0);
    step();
    rst = 1'b0;

    // I read of 0x40, memory answers 5 cycles after the strobe rises.
    mem_lat = 5;
    icache_read = 1'b1;
    icache_address = 32'h40;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("t1_pmem_read", LW'(pmem_read), LW'(k >= 1 && k <= 6));
      check("t1_icache_resp", LW'(icache_resp), LW'(k == 6));
      check("t1_dcache_resp", LW'(dcache_resp), '0);
      check("t1_grant", LW'(grant), (k >= 1 && k <= 6) ? LW'(1) : LW'(0));
      if (k == 1) check("t1_addr", LW'(pmem_address), LW'(32'h40));
      if (k == 6) check("t1_rdata", icache_rdata, a5_line);
      step();
      if (k == 6) icache_read = 1'b0;
    end

    // D write-back of 0x1000.
    mem_lat = 2;
    dcache_write = 1'b1;
    dcache_address = 32'h1000;
    dcache_wdata = wb_line;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t2_pmem_write", LW'(pmem_write), LW'(k >= 1 && k <= 3));
      check("t2_pmem_read", LW'(pmem_read), '0);
      check("t2_dcache_resp", LW'(dcache_resp), LW'(k == 3));
      check("t2_icache_resp", LW'(icache_resp), '0);
      if (k == 1) begin
        check("t2_wdata", pmem_wdata, wb_line);
        check("t2_addr", LW'(pmem_address), LW'(32'h1000));
      end
      step();
      if (k == 3) dcache_write = 1'b0;
    end

    // Simultaneous I and D after reset: D first, then I wins the next tie.
    do_reset();
    mem_lat = 1;
    icache_read = 1'b1;
    icache_address = 32'h80;
    dcache_read = 1'b1;
    dcache_address = 32'h100;
    wait_any_resp(30, ok);
    check("t3_first_seen", LW'(ok), LW'(1'b1));
    check("t3_first_is_d", LW'({icache_resp, dcache_resp}), LW'(2'b01));
    step();
    dcache_address = 32'h140;  // D immediately requests again: a real tie next time
    wait_any_resp(30, ok);
    check("t3_second_seen", LW'(ok), LW'(1'b1));
    check("t3_second_is_i", LW'({icache_resp, dcache_resp}), LW'(2'b10));
    check("t3_i_rdata", icache_rdata, mem_get(32'h80));
    step();
    icache_read = 1'b0;
    wait_any_resp(30, ok);
    check("t3_third_seen", LW'(ok), LW'(1'b1));
    check("t3_third_is_d", LW'({icache_resp, dcache_resp}), LW'(2'b01));
    check("t3_d_rdata", dcache_rdata, mem_get(32'h140));
    step();
    dcache_read = 1'b0;

    // Requester changes its address mid-transaction.
    step();
    mem_lat = 4;
    icache_read = 1'b1;
    icache_address = 32'h200;
    step();
    step();
    icache_address = 32'hDEAD_BEE0;
    for (int k = 2; k < 6; k++) begin
      @(negedge clk);
      check("t4_addr_held", LW'(pmem_address), LW'(32'h200));
      check("t4_resp", LW'(icache_resp), LW'(k == 5));
      step();
    end
    icache_read = 1'b0;
    icache_address = '0;

    // Request held through resp and the dead cycle: no second grant.
    step();
    mem_lat = 0;
    icache_read = 1'b1;
    icache_address = 32'h240;
    wait_any_resp(20, ok);
    check("t5_resp_seen", LW'(ok), LW'(1'b1));
    step();
    @(negedge clk);
    check("t5_done_strobes", LW'({pmem_read, pmem_write}), '0);
    check("t5_done_grant", LW'(grant), '0);
    step();
    icache_read = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_no_regrant", LW'({grant, pmem_read, icache_resp}), '0);
      step();
    end

    // Asynchronous reset in the middle of a D fill.
    mem_lat = 10;
    dcache_read = 1'b1;
    dcache_address = 32'h300;
    step();
    step();
    @(negedge clk);
    check("t6_pre_read", LW'(pmem_read), LW'(1'b1));
    check("t6_pre_grant", LW'(grant), LW'(2));
    #1;
    rst = 1'b1;
    #1;
    check("t6_async_grant", LW'(grant), '0);
    check("t6_async_strobes", LW'({pmem_read, pmem_write}), '0);
    check("t6_async_resps", LW'({icache_resp, dcache_resp}), '0);
    check("t6_async_addr", LW'(pmem_address), '0);
    dcache_read = 1'b0;
    step();
    step();
    rst = 1'b0;
    mem_lat = 2;
    icache_read = 1'b1;
    icache_address = 32'h40;
    wait_any_resp(20, ok);
    check("t6_after_seen", LW'(ok), LW'(1'b1));
    check("t6_after_is_i", LW'({icache_resp, dcache_resp}), LW'(2'b10));
    check("t6_after_rdata", icache_rdata, a5_line);
    step();
    icache_read = 1'b0;
    step();

    // Random traffic from both caches, random memory latency.
    mem_lat = -1;
    i_done = 1'b0;
    d_done = 1'b0;
    n_i_resp = 0;
    n_d_resp = 0;
    n_i_issued = 0;
    n_d_issued = 0;
    for (int c = 0; c < 800; c++) begin
      step();
      if (i_done) begin icache_read = 1'b0; i_done = 1'b0; end
      if (d_done) begin dcache_read = 1'b0; dcache_write = 1'b0; d_done = 1'b0; end
      if (!icache_read && $urandom_range(0, 3) == 0) begin
        icache_read = 1'b1;
        icache_address = rand_addr();
        n_i_issued++;
      end
      if (!dcache_read && !dcache_write && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) dcache_write = 1'b1;
        else dcache_read = 1'b1;
        dcache_address = rand_addr();
        dcache_wdata = rand_line();
        n_d_issued++;
      end
    end
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      step();
      if (i_done) begin icache_read = 1'b0; i_done = 1'b0; end
      if (d_done) begin dcache_read = 1'b0; dcache_write = 1'b0; d_done = 1'b0; end
      if (!icache_read && !dcache_read && !dcache_write) ok = 1'b1;
    end
    check("rand_drained", LW'(ok), LW'(1'b1));
    check("rand_i_count", LW'(n_i_resp), LW'(n_i_issued));
    check("rand_d_count", LW'(n_d_resp), LW'(n_d_issued));
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
